// File: rtl/btn_pkg.sv
// Shared types and 12 MHz default timing constants for the push-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 5 ms settle, 500 ms to first repeat, 100 ms repeat period at 12 MHz.
  localparam int STABLE_CYCLES_12M = 60000;
  localparam int REPEAT_DELAY_12M  = 6000000;
  localparam int REPEAT_PERIOD_12M = 1200000;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-FF synchroniser, bounce-filter FSM with a saturating
// stability counter, and (with BTN_DEBOUNCE_REPEAT_EN) a hold auto-repeat counter.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_12M
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_12M,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_12M
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             r_sync1, r_sync2;
  logic             w_sync;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic             r_level, r_press, r_release;
  logic             w_rpt_fire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync    = r_sync2;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt, w_rpt_lim;
  logic             r_rpt_first, w_held;

  // Counts only while the pin agrees with "pressed"; a bounce in RELEASE_WAIT freezes it.
  assign w_held     = w_sync && (r_state == PRESSED || r_state == RELEASE_WAIT);
  assign w_rpt_lim  = r_rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
  assign w_rpt_fire = w_held && (r_rpt == w_rpt_lim);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rpt       <= '0;
      r_rpt_first <= 1'b1;
    end else if (r_state == RELEASED || r_state == PRESS_WAIT) begin
      r_rpt       <= '0;
      r_rpt_first <= 1'b1;
    end else if (w_rpt_fire) begin
      r_rpt       <= '0;
      r_rpt_first <= 1'b0;
    end else if (w_held) begin
      r_rpt <= r_rpt + 1'b1;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_rpt_fire;
      r_release <= 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_sync) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!w_sync) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        PRESSED: begin
          if (!w_sync) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (w_sync) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: polarity normalisation plus N_BTN independent debounce channels.
// Optional auto-repeat on held buttons is enabled with `define BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int               N_BTN         = 4,
  parameter int               STABLE_CYCLES = STABLE_CYCLES_12M,
  parameter logic [N_BTN-1:0] ACTIVE_LOW    = N_BTN'(4'b0001),
  parameter int               REPEAT_DELAY  = REPEAT_DELAY_12M,
  parameter int               REPEAT_PERIOD = REPEAT_PERIOD_12M
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("btn_debounce: STABLE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // Everything downstream of here sees 1 = pressed.
  logic [N_BTN-1:0] w_btn;
  assign w_btn = btn_raw ^ ACTIVE_LOW;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES)
`ifdef BTN_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_btn     (w_btn[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a run-length reference model checked every cycle.
module tb_btn_debounce;

  localparam int S = 8;
  localparam int D = 20;
  localparam int P = 5;
  localparam logic [3:0] AL = 4'b0001;
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = 4'b0001;
  logic [3:0] lvl, prs, rel;

  int n_cmp = 0;
  int n_err = 0;
  int pcnt[4];
  int rcnt[4];
  int b1, b2, b3;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN(4), .STABLE_CYCLES(S), .ACTIVE_LOW(AL),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .btn_raw(btn_raw),
    .btn_level(lvl), .btn_press(prs), .btn_release(rel)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference: the filter sees the pin two edges late; a change is accepted on the
  // S-th consecutive sample that disagrees with the accepted level. Repeats fire
  // after D, D+P, D+2P... agreeing samples while pressed.
  logic [3:0] d1, d2, s, m_lvl, m_prs, m_rel;
  int run[4];
  int held[4];

  always @(posedge clk) begin
    if (!rst_n) begin
      d1 = '0; d2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int i = 0; i < 4; i++) begin run[i] = 0; held[i] = 0; end
    end else begin
      s = d2; d2 = d1; d1 = btn_raw ^ AL;
      m_prs = '0; m_rel = '0;
      for (int i = 0; i < 4; i++) begin
        if (s[i] != m_lvl[i]) begin
          run[i]++;
          if (run[i] == S) begin
            m_lvl[i] = s[i];
            run[i] = 0;
            held[i] = 0;
            if (s[i]) m_prs[i] = 1'b1;
            else      m_rel[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
          if (m_lvl[i]) begin
            held[i]++;
            if (RPT && (held[i] == D || (held[i] > D && (held[i] - D) % P == 0)))
              m_prs[i] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_level", lvl, 32'h0);
      chk("rst_press", prs, 32'h0);
      chk("rst_release", rel, 32'h0);
    end else begin
      chk("level", lvl, m_lvl);
      chk("press", prs, m_prs);
      chk("release", rel, m_rel);
      chk("press_release_excl", prs & rel, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      if (prs[i] === 1'b1) pcnt[i]++;
      if (rel[i] === 1'b1) rcnt[i]++;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin pcnt[i] = 0; rcnt[i] = 0; end
    tick(3);
    chk("reset_lvl", lvl, 32'h0);
    chk("reset_prs", prs, 32'h0);
    rst_n = 1'b1;
    tick(100);
    chk("idle_presses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 32'd0);
    chk("idle_releases", rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3], 32'd0);

    // bit 1 press and release, k+9 latency
    btn_raw = 4'b0011;
    tick(9);  chk("b1_early", prs, 32'h0);
    tick(1);  chk("b1_press", prs, 32'h2); chk("b1_level", lvl, 32'h2);
    tick(1);  chk("b1_pulse_width", prs, 32'h0);
    btn_raw = 4'b0001;
    tick(9);  chk("b1_rel_early", rel, 32'h0);
    tick(1);  chk("b1_release", rel, 32'h2); chk("b1_level_off", lvl, 32'h0);
    tick(1);  chk("b1_rel_width", rel, 32'h0);

    // bit 2 bounce then held
    b2 = pcnt[2];
    btn_raw = 4'b0101; tick(5);
    btn_raw = 4'b0001; tick(2);
    btn_raw = 4'b0101;
    tick(9);  chk("b2_early", prs, 32'h0);
    tick(1);  chk("b2_press", prs, 32'h4);
    tick(3);  chk("b2_single", pcnt[2] - b2, 32'd1);
    btn_raw = 4'b0001; tick(12);

    // 7-cycle glitch on bit 3 never reaches outputs
    b3 = pcnt[3];
    btn_raw = 4'b1001; tick(7);
    btn_raw = 4'b0001; tick(15);
    chk("b3_glitch", pcnt[3] - b3, 32'd0);
    chk("b3_glitch_lvl", lvl, 32'h0);

    // BTN_N low and bit 3 high together
    btn_raw = 4'b1000;
    tick(9);  chk("sim_early", prs, 32'h0);
    tick(1);  chk("sim_press", prs, 32'h9); chk("sim_level", lvl, 32'h9);
    btn_raw = 4'b0001; tick(12);
    chk("sim_rel_lvl", lvl, 32'h0);

    // reset mid PRESS_WAIT, then while PRESSED, button held throughout
    b1 = pcnt[1];
    btn_raw = 4'b0011; tick(4);
    rst_n = 1'b0; #1;
    chk("rst_pw_lvl", lvl, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(9);  chk("rst_pw_early", prs, 32'h0);
    tick(1);  chk("rst_pw_press", prs, 32'h2); chk("rst_pw_level", lvl, 32'h2);
    tick(3);
    rst_n = 1'b0; #1;
    chk("rst_async_lvl", lvl, 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(9);  chk("rst_p_early", prs, 32'h0);
    tick(1);  chk("rst_p_press", prs, 32'h2);
    chk("rst_press_count", pcnt[1] - b1, 32'd2);
    btn_raw = 4'b0001; tick(12);

    // hold bit 1 for 60 cycles after acceptance
    b1 = pcnt[1];
    btn_raw = 4'b0011;
    tick(10); chk("rpt_first", prs, 32'h2);
    tick(20); chk("rpt_delay", prs, RPT ? 32'h2 : 32'h0);
    tick(40); chk("rpt_count", pcnt[1] - b1, RPT ? 32'd10 : 32'd1);
    btn_raw = 4'b0001; tick(12);
    chk("rpt_rel_lvl", lvl, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
